// File: rtl/stepper_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stepper_monitor: decodes observed half-step coil patterns into a signed  |
// | position count, direction, step strobe, fault and stall indications.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module stepper_monitor #(
  parameter int POS_WIDTH    = 16,
  parameter int DEBOUNCE     = 2,
  parameter int STALL_CYCLES = 50000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [3:0]                  coils,
  input  logic                        clear,
  output logic signed [POS_WIDTH-1:0] position,
  output logic                        dir,
  output logic                        step_pulse,
  output logic                        energised,
  output logic                        fault,
  output logic                        stalled
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int SW = $clog2(STALL_CYCLES + 1);
  localparam logic [DW-1:0] DEB_N     = DW'(DEBOUNCE);
  localparam logic [SW-1:0] STALL_N   = SW'(STALL_CYCLES);
  localparam logic [SW-1:0] STALL_PRE = SW'(STALL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  logic [3:0]                  sync1_q, sync2_q, ref_q;
  logic [DW-1:0]               stab_q, stab_d;
  state_t                      state_q;
  logic signed [POS_WIDTH-1:0] pos_q;
  logic                        dir_q, pulse_q, energ_q, fault_q, stalled_q;
  logic [SW-1:0]               stall_cnt_q;

  logic       accept, new_off, both, step_up, step_dn, bad, cur_legal, stall_clr;
  logic [3:0] new_dec, ref_dec;
  logic [2:0] diff;

  // Returns {legal, half-step index}; 0000 and illegal patterns decode as not legal.
  function automatic logic [3:0] decode(input logic [3:0] p);
    case (p)
      4'b0001: decode = {1'b1, 3'd0};
      4'b0011: decode = {1'b1, 3'd1};
      4'b0010: decode = {1'b1, 3'd2};
      4'b0110: decode = {1'b1, 3'd3};
      4'b0100: decode = {1'b1, 3'd4};
      4'b1100: decode = {1'b1, 3'd5};
      4'b1000: decode = {1'b1, 3'd6};
      4'b1001: decode = {1'b1, 3'd7};
      default: decode = 4'b0000;
    endcase
  endfunction

  always_comb begin
    stab_d = stab_q;
    if (sync1_q != sync2_q) begin
      stab_d = DW'(1);
    end else if (stab_q != DEB_N) begin
      stab_d = stab_q + DW'(1);
    end
    new_dec   = decode(sync2_q);
    ref_dec   = decode(ref_q);
    accept    = (stab_q == DEB_N) && (sync2_q != ref_q);
    new_off   = (sync2_q == 4'b0000);
    both      = new_dec[3] && ref_dec[3];
    diff      = new_dec[2:0] - ref_dec[2:0];
    step_up   = accept && both && (diff == 3'd1);
    step_dn   = accept && both && (diff == 3'd7);
    bad       = accept && ((!new_dec[3] && !new_off) ||
                           (both && (diff != 3'd1) && (diff != 3'd7)));
    cur_legal = accept ? new_dec[3] : ref_dec[3];
    stall_clr = (state_q != S_RUN) || step_up || step_dn || bad || (accept && new_off);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
      stab_q  <= '0;
    end else begin
      sync1_q <= coils;
      sync2_q <= sync1_q;
      stab_q  <= stab_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q       <= 4'b0000;
      state_q     <= S_OFF;
      pos_q       <= '0;
      dir_q       <= 1'b0;
      pulse_q     <= 1'b0;
      energ_q     <= 1'b0;
      fault_q     <= 1'b0;
      stall_cnt_q <= '0;
      stalled_q   <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      energ_q <= cur_legal;
      if (accept) begin
        ref_q <= sync2_q;
      end

      // Clear overrides any step or fault event seen in the same cycle.
      if (clear) begin
        pos_q   <= '0;
        fault_q <= 1'b0;
        state_q <= cur_legal ? S_RUN : S_OFF;
      end else begin
        case (state_q)
          S_OFF: begin
            if (bad) begin
              state_q <= S_FAULT;
              fault_q <= 1'b1;
            end else if (accept && new_dec[3]) begin
              state_q <= S_RUN;
            end
          end
          S_RUN: begin
            if (bad) begin
              state_q <= S_FAULT;
              fault_q <= 1'b1;
            end else if (step_up) begin
              pos_q   <= pos_q + POS_WIDTH'(1);
              dir_q   <= 1'b1;
              pulse_q <= 1'b1;
            end else if (step_dn) begin
              pos_q   <= pos_q - POS_WIDTH'(1);
              dir_q   <= 1'b0;
              pulse_q <= 1'b1;
            end else if (accept && new_off) begin
              state_q <= S_OFF;
            end
          end
          default: ;
        endcase
      end

      if (stall_clr) begin
        stall_cnt_q <= '0;
        stalled_q   <= 1'b0;
      end else begin
        if (stall_cnt_q != STALL_N) begin
          stall_cnt_q <= stall_cnt_q + SW'(1);
        end
        if (stall_cnt_q >= STALL_PRE) begin
          stalled_q <= 1'b1;
        end
      end
    end
  end

  assign position   = pos_q;
  assign dir        = dir_q;
  assign step_pulse = pulse_q;
  assign energised  = energ_q;
  assign fault      = fault_q;
  assign stalled    = stalled_q;

endmodule
`default_nettype wire

// File: tb/tb_stepper_monitor.sv
`default_nettype none
// Directed bench for stepper_monitor: a 16-bit instance for the main checks and
// a 4-bit instance sharing the same inputs for position wrap.
module tb_stepper_monitor;

  localparam int LAT = 4;  // DEBOUNCE + 2

  logic        clk = 1'b0;
  logic        rst, clear;
  logic [3:0]  coils;
  logic signed [15:0] position;
  logic        dir, step_pulse, energised, fault, stalled;
  logic signed [3:0]  w4_position;
  logic        w4_dir, w4_step_pulse, w4_energised, w4_fault, w4_stalled;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stepper_monitor #(.POS_WIDTH(16), .DEBOUNCE(2), .STALL_CYCLES(20)) u_dut (
    .clk(clk), .rst(rst), .coils(coils), .clear(clear),
    .position(position), .dir(dir), .step_pulse(step_pulse),
    .energised(energised), .fault(fault), .stalled(stalled)
  );

  stepper_monitor #(.POS_WIDTH(4), .DEBOUNCE(2), .STALL_CYCLES(20)) u_w4 (
    .clk(clk), .rst(rst), .coils(coils), .clear(clear),
    .position(w4_position), .dir(w4_dir), .step_pulse(w4_step_pulse),
    .energised(w4_energised), .fault(w4_fault), .stalled(w4_stalled)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply a pattern and hold it, checking the strobe lands exactly LAT cycles later.
  task automatic drive_hold(input logic [3:0] p, input logic exp_pulse, input int hold,
                            input string tag);
    coils = p;
    for (int c = 1; c <= hold; c++) begin
      tick();
      chk(tag, step_pulse, (exp_pulse && c == LAT));
    end
  endtask

  logic [3:0] ccw [8];
  logic [3:0] cw  [8];

  initial begin
    ccw = '{4'b0011, 4'b0010, 4'b0110, 4'b0100, 4'b1100, 4'b1000, 4'b1001, 4'b0001};
    cw  = '{4'b1001, 4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001};
    rst = 1'b1; clear = 1'b0; coils = 4'b0000;
    repeat (3) tick();
    chk("rst_pos", position, 0);
    chk("rst_dir", dir, 0);
    chk("rst_pulse", step_pulse, 0);
    chk("rst_energ", energised, 0);
    chk("rst_fault", fault, 0);
    chk("rst_stall", stalled, 0);
    rst = 1'b0;

    // Three CCW steps from power-on.
    drive_hold(4'b0000, 1'b0, 10, "off_hold");
    drive_hold(4'b0001, 1'b0, 10, "energise");
    chk("energ_on", energised, 1);
    drive_hold(4'b0011, 1'b1, 10, "step1");
    drive_hold(4'b0010, 1'b1, 10, "step2");
    drive_hold(4'b0110, 1'b1, 10, "step3");
    chk("pos3", position, 3);
    chk("dir3", dir, 1);
    chk("nofault3", fault, 0);

    // Off, clear, then CW steps from 1000 and an illegal jump.
    drive_hold(4'b0000, 1'b0, 6, "to_off");
    chk("energ_off", energised, 0);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clear_pos", position, 0);
    drive_hold(4'b1000, 1'b0, 6, "from1000");
    drive_hold(4'b1100, 1'b1, 6, "cw1");
    drive_hold(4'b0100, 1'b1, 6, "cw2");
    chk("pos_m2", position, -2);
    chk("dir_cw", dir, 0);
    drive_hold(4'b0001, 1'b0, 6, "jump");
    chk("fault_set", fault, 1);
    drive_hold(4'b1001, 1'b0, 6, "in_fault");
    chk("fault_pos", position, -2);
    chk("fault_sticky", fault, 1);
    chk("fault_dir", dir, 0);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("fault_clr", fault, 0);
    chk("fault_clr_pos", position, 0);
    drive_hold(4'b0001, 1'b1, 6, "wrap7to0");
    chk("pos_after_fault", position, 1);
    chk("dir_after_fault", dir, 1);

    // Full revolution each way.
    clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 0; i < 8; i++) drive_hold(ccw[i], 1'b1, 6, "rev_ccw");
    chk("rev_pos8", position, 8);
    chk("rev_w4", w4_position, -8);
    for (int i = 0; i < 8; i++) drive_hold(cw[i], 1'b1, 6, "rev_cw");
    chk("rev_pos0", position, 0);
    chk("rev_dir", dir, 0);
    chk("rev_fault", fault, 0);

    // One-cycle glitch is ignored.
    coils = 4'b0011; tick();
    chk("glitch_pulse0", step_pulse, 0);
    drive_hold(4'b0001, 1'b0, 10, "glitch");
    chk("glitch_fault", fault, 0);
    chk("glitch_pos", position, 0);

    // Walk to +7, then one more step wraps the narrow counter.
    for (int i = 0; i < 7; i++) drive_hold(ccw[i], 1'b1, 6, "to7");
    chk("w4_pos7", w4_position, 7);
    drive_hold(4'b0001, 1'b1, 6, "wrap_step");
    chk("w4_wrap", w4_position, -8);
    chk("w4_wrap_fault", w4_fault, 0);
    chk("pos8_again", position, 8);

    // Clear coinciding with an accepted step.
    coils = 4'b0011;
    repeat (LAT - 1) tick();
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_step_pulse", step_pulse, 0);
    chk("clr_step_pos", position, 0);
    chk("clr_step_w4", w4_position, 0);
    drive_hold(4'b0010, 1'b1, 6, "after_clr");
    chk("after_clr_pos", position, 1);

    // Stall detection.
    coils = 4'b0110;
    for (int c = 1; c <= 26; c++) begin
      tick();
      if (c == LAT) chk("stall_step", step_pulse, 1);
      chk("stall_rise", stalled, (c >= LAT + 20));
    end
    chk("stall_pos", position, 2);
    coils = 4'b0100;
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk("stall_drop", stalled, (c < LAT));
    end
    chk("stall_step_pos", position, 3);
    repeat (20) tick();
    chk("stall_again", stalled, 1);
    coils = 4'b0000;
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk("stall_off", stalled, (c < LAT));
    end
    chk("off_energ", energised, 0);
    chk("off_pulse", step_pulse, 0);

    // Illegal pattern from off.
    drive_hold(4'b1111, 1'b0, 6, "illegal");
    chk("illegal_fault", fault, 1);
    chk("illegal_energ", energised, 0);
    chk("illegal_pos", position, 3);

    // Reset beats clear and a pending pattern.
    coils = 4'b0001; rst = 1'b1; clear = 1'b1;
    tick();
    chk("rstp_pos", position, 0);
    chk("rstp_fault", fault, 0);
    chk("rstp_dir", dir, 0);
    chk("rstp_energ", energised, 0);
    rst = 1'b0; clear = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stepper_monitor.md
STEPPER_MONITOR -- requirements
Module: stepper_monitor

Interface
REQ-001 Parameter POS_WIDTH, default 16: width of the signed step-position counter.
REQ-002 Parameter DEBOUNCE, default 2, minimum 1: consecutive identical synchronised samples required before a coil pattern is accepted.
REQ-003 Parameter STALL_CYCLES, default 50000: cycles without an accepted step while energised before stall is flagged.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 coils  input  4  observed coil-drive pattern from the stepper driver pins.
REQ-007 clear  input  1  synchronous: zero the position counter and clear fault.
REQ-008 position  output  POS_WIDTH  signed step count, two's complement.
REQ-009 dir  output  1  direction of last counted step: 1 = counter-clockwise, 0 = clockwise.
REQ-010 step_pulse  output  1  one-cycle strobe per counted step.
REQ-011 energised  output  1  accepted pattern is a legal non-zero pattern.
REQ-012 fault  output  1  sticky illegal-pattern or illegal-transition flag.
REQ-013 stalled  output  1  level: energised with no step for STALL_CYCLES cycles.

Function
REQ-014 coils SHALL pass through a 2-flop synchroniser; debounce SHALL act on the second flop's output.
REQ-015 A pattern SHALL be accepted once the synchronised value has been identical for DEBOUNCE consecutive cycles; coils change to step_pulse high latency SHALL be exactly DEBOUNCE+2 cycles.
REQ-016 Legal half-step indices: 0001=0, 0011=1, 0010=2, 0110=3, 0100=4, 1100=5, 1000=6, 1001=7; 0000 = off; all other patterns illegal.
REQ-017 Accepted index change of +1 mod 8 (including 7->0) SHALL increment position, set dir=1 and pulse step_pulse.
REQ-018 Accepted index change of -1 mod 8 (including 0->7) SHALL decrement position, set dir=0 and pulse step_pulse.
REQ-019 Accepted index change of +/-2..4 mod 8, or any accepted illegal pattern, SHALL set fault with no position change.
REQ-020 Transitions 0000->legal and legal->0000 SHALL NOT count a step or set fault.
REQ-021 Position SHALL wrap modulo 2^POS_WIDTH (max positive +1 -> most negative) with no flag.
REQ-022 State machine: OFF (last accepted pattern 0000), RUN (legal non-zero), FAULT (fault set).
REQ-023 Transitions: OFF->RUN on legal pattern; RUN->OFF on 0000; OFF/RUN->FAULT on REQ-019 event; FAULT->OFF or FAULT->RUN only on clear, chosen by the current accepted pattern.
REQ-024 In FAULT, position, dir and step_pulse SHALL be frozen and low respectively; accepted patterns still update the stored reference index.
REQ-025 clear SHALL zero position and fault in the next cycle; when clear coincides with an accepted step, clear wins, position = 0, step_pulse = 0, and the reference index still updates.
REQ-026 Stall counter SHALL run only in RUN, reset on every counted step and on leaving RUN; stalled SHALL assert on reaching STALL_CYCLES and deassert on the next step, on 0000, or on fault.
REQ-027 Glitches shorter than DEBOUNCE cycles SHALL have no effect on any output.

Reset
REQ-028 rst SHALL force position=0, dir=0, step_pulse=0, energised=0, fault=0, stalled=0, state OFF, synchroniser and reference = 0000, all counters = 0.
REQ-029 rst SHALL take priority over clear and over any accepted pattern in the same cycle.

Verification
REQ-030 Drive 0000,0001,0011,0010,0110, each held 10 cycles -> three step_pulses, position=3, dir=1, each pulse exactly DEBOUNCE+2 cycles after its edge.
REQ-031 From 1000, drive 1100,0100,0001,1001 (the last a -1 step from index 0 to 7) -> 0100->0001 sets fault, position stays -2, all later steps ignored until clear.
REQ-032 Full CCW revolution 0001..1001->0001 (8 steps) then 8 CW steps -> position +8 then 0, dir ends 0, no fault.
REQ-033 One-cycle glitch 0011 inside a held 0001 with DEBOUNCE=2 -> no step_pulse, no fault.
REQ-034 POS_WIDTH=4, position=7, one CCW step -> position=-8; clear asserted in the same cycle as a step -> position=0, step_pulse=0.
REQ-035 STALL_CYCLES=20, hold 0011 -> stalled high 20 cycles after last step; next legal step -> stalled low, position updated.
